// File: rtl/test_packet_source_if.sv
// rtl/test_packet_source_if.sv - Avalon-ST style source/sink stream bundle
interface test_packet_source_if #(
  parameter int WIDTH = 32
);
  localparam int EW = $clog2(WIDTH / 8);

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             sop;
  logic             eop;
  logic [EW-1:0]    empty;
  logic             ready;

  modport master (output data, valid, sop, eop, empty, input ready);
  modport slave  (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/test_packet_source.sv
// rtl/test_packet_source.sv - programmable packet generator with backpressure and progress counter
module test_packet_source #(
  parameter int          WIDTH     = 32,
  parameter int          MIN_LEN   = 1,
  parameter int          MAX_LEN   = 1518,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
  parameter logic [7:0]  FILL      = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic [1:0]   mode,
  input  logic [15:0]  pkt_len,
  input  logic [15:0]  pkt_count,
  input  logic [7:0]   gap,
  output logic         busy,
  output logic [31:0]  pkts_sent,
  test_packet_source_if.master src
);

  localparam int unsigned BYTES = WIDTH / 8;
  localparam int          EW    = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, SEND, GAP_WAIT} state_t;

  state_t        state;
  logic          valid_q;
  logic [1:0]    mode_q;
  logic [15:0]   len_q;
  logic [15:0]   beats_q;
  logic [EW-1:0] empty_q;
  logic [15:0]   count_q;
  logic [7:0]    gap_q;
  logic [15:0]   k_q;
  logic [31:0]   lfsr_q;
  logic [7:0]    gap_cnt;
  logic [15:0]   done_q;
  logic          stop_seen;

  logic [15:0]   len_in;
  logic [15:0]   beats_in;
  logic [EW-1:0] empty_in;
  logic          last;
  logic          xfer;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  // Builds beat k; bytes past the packet length are forced to zero.
  function automatic logic [WIDTH-1:0] make_word(input logic [1:0] m, input logic [15:0] k,
                                                 input logic [31:0] lf, input logic [15:0] len);
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] kw;
    logic [31:0]      n;
    w  = '0;
    kw = WIDTH'(k);
    for (int j = 0; j < int'(BYTES); j++) begin
      n = 32'(k) * BYTES + 32'(j);
      case (m)
        2'd0:    w[WIDTH-1-8*j -: 8] = n[7:0];
        2'd1:    w[WIDTH-1-8*j -: 8] = kw[WIDTH-1-8*j -: 8];
        2'd2:    w[WIDTH-1-8*j -: 8] = lf[((WIDTH-8-8*j) % 32) +: 8];
        default: w[WIDTH-1-8*j -: 8] = FILL;
      endcase
      if (n >= 32'(len)) w[WIDTH-1-8*j -: 8] = 8'h00;
    end
    return w;
  endfunction

  always_comb begin
    len_in = pkt_len;
    if (pkt_len < 16'(MIN_LEN))      len_in = 16'(MIN_LEN);
    else if (pkt_len > 16'(MAX_LEN)) len_in = 16'(MAX_LEN);
    beats_in = 16'((32'(len_in) + BYTES - 32'd1) / BYTES);
    empty_in = EW'(32'(beats_in) * BYTES - 32'(len_in));
  end

  assign last = (k_q == beats_q - 16'd1);
  assign xfer = valid_q && src.ready;

  assign src.valid = valid_q;
  assign src.sop   = valid_q && (k_q == 16'd0);
  assign src.eop   = valid_q && last;
  assign src.empty = (valid_q && last) ? empty_q : '0;
  assign src.data  = valid_q ? make_word(mode_q, k_q, lfsr_q, len_q) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      mode_q    <= '0;
      len_q     <= '0;
      beats_q   <= '0;
      empty_q   <= '0;
      count_q   <= '0;
      gap_q     <= '0;
      k_q       <= '0;
      lfsr_q    <= '0;
      gap_cnt   <= '0;
      done_q    <= '0;
      stop_seen <= 1'b0;
      pkts_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            len_q     <= len_in;
            beats_q   <= beats_in;
            empty_q   <= empty_in;
            count_q   <= pkt_count;
            gap_q     <= gap;
            k_q       <= '0;
            lfsr_q    <= LFSR_SEED;
            done_q    <= '0;
            stop_seen <= 1'b0;
            pkts_sent <= '0;
            valid_q   <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (stop) stop_seen <= 1'b1;
          if (xfer) begin
            if (last) begin
              pkts_sent <= pkts_sent + 32'd1;
              done_q    <= done_q + 16'd1;
              k_q       <= '0;
              lfsr_q    <= LFSR_SEED;
              if ((count_q != 16'd0 && done_q + 16'd1 == count_q) || stop_seen || stop) begin
                state   <= IDLE;
                valid_q <= 1'b0;
              end else if (gap_q != 8'd0) begin
                state   <= GAP_WAIT;
                gap_cnt <= gap_q;
                valid_q <= 1'b0;
              end
            end else begin
              k_q    <= k_q + 16'd1;
              lfsr_q <= lfsr_step(lfsr_q);
            end
          end
        end
        GAP_WAIT: begin
          if (stop || stop_seen) begin
            state <= IDLE;
          end else if (gap_cnt <= 8'd1) begin
            state   <= SEND;
            valid_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
